mem_access_ctrl: RTL and testbench

//  Request-side controller sitting directly upstream of port A of DualPortMemory (16-bit, 1024-word, sync read).

---
 rtl/mem_ctrl_pkg.sv | 14 +
 rtl/mem_fill_seq.sv | 66 ++++++
 rtl/mem_access_ctrl.sv | 142 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared widths and FSM encoding for the port-A memory access controller.
package mem_ctrl_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ADDR_W = 10;

    typedef enum logic [1:0] {
        IDLE,
        RD_ISSUE,
        RD_CAPT,
        FILL
    } ctrl_state_e;

endpackage

// File: rtl/mem_fill_seq.sv
// Fill sequencer: walks an address/remaining-count pair one word per advance and
// pulses done once the count is exhausted. Only instantiated with MEM_CTRL_FILL_EN.
module mem_fill_seq
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] value,
    input  logic              adv,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              active,
    output logic              done
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [DATA_W-1:0] val_q, val_d;
    logic              done_q, done_d;

    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        val_d  = val_q;
        done_d = 1'b0;
        if (start) begin
            addr_d = base;
            rem_d  = len;
            val_d  = value;
        end else if (adv) begin
            if (rem_q != '0) begin
                // Address wraps naturally at 2**ADDR_W.
                addr_d = addr_q + ADDR_W'(1);
                rem_d  = rem_q - (ADDR_W + 1)'(1);
            end else begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
            rem_q  <= '0;
            val_q  <= '0;
            done_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
            val_q  <= val_d;
            done_q <= done_d;
        end
    end

    assign addr   = addr_q;
    assign data   = val_q;
    assign active = (rem_q != '0);
    assign done   = done_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// CPU load/store front end for a sync-read memory port; optional range fill engine
// is enabled by defining MEM_CTRL_FILL_EN.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
`ifdef MEM_CTRL_FILL_EN
    input  logic              fill_start,
    input  logic [ADDR_W-1:0] fill_base,
    input  logic [ADDR_W:0]   fill_len,
    input  logic [DATA_W-1:0] fill_value,
    output logic              fill_done,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_q
);

    ctrl_state_e       state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              mem_we_q, mem_we_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              fill_req;
    logic              accept;

`ifdef MEM_CTRL_FILL_EN
    logic              fill_go;
    logic [ADDR_W-1:0] fill_addr;
    logic [DATA_W-1:0] fill_data;
    logic              fill_active;

    assign fill_req = fill_start;
    assign fill_go  = (state_q == IDLE) & fill_start;

    mem_fill_seq #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fill_seq (
        .clk    (clk),
        .reset  (reset),
        .start  (fill_go),
        .base   (fill_base),
        .len    (fill_len),
        .value  (fill_value),
        .adv    (state_q == FILL),
        .addr   (fill_addr),
        .data   (fill_data),
        .active (fill_active),
        .done   (fill_done)
    );
`else
    assign fill_req = 1'b0;
`endif

    // A pending fill request steals the cycle from any CPU request.
    assign req_ready = (state_q == IDLE) & ~reset & ~fill_req;
    assign accept    = req_valid & req_ready;

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        mem_we_d    = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            IDLE: begin
                if (fill_req) begin
                    state_d = FILL;
                end else if (accept) begin
                    mem_addr_d = req_addr;
                    if (req_we) begin
                        mem_data_d = req_wdata;
                        mem_we_d   = 1'b1;
                    end else begin
                        state_d = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: state_d = RD_CAPT;
            RD_CAPT: begin
                // Memory registered q during RD_ISSUE; it is valid now.
                rsp_rdata_d = mem_q;
                rsp_valid_d = 1'b1;
                state_d     = IDLE;
            end
`ifdef MEM_CTRL_FILL_EN
            FILL: begin
                if (fill_active) begin
                    mem_addr_d = fill_addr;
                    mem_data_d = fill_data;
                    mem_we_d   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            mem_we_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            mem_we_q    <= mem_we_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;
    assign mem_we    = mem_we_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = (state_q == RD_ISSUE) | (state_q == RD_CAPT) | (state_q == FILL);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl with a sync-read memory attached; fill tests run when
// MEM_CTRL_FILL_EN is defined.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [9:0]  req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        busy;
    logic [9:0]  mem_addr;
    logic [15:0] mem_data;
    logic        mem_we;
    logic [15:0] mem_q;
`ifdef MEM_CTRL_FILL_EN
    logic        fill_start = 1'b0;
    logic [9:0]  fill_base = '0;
    logic [10:0] fill_len = '0;
    logic [15:0] fill_value = '0;
    logic        fill_done;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.DATA_W(16), .ADDR_W(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .busy       (busy),
`ifdef MEM_CTRL_FILL_EN
        .fill_start (fill_start),
        .fill_base  (fill_base),
        .fill_len   (fill_len),
        .fill_value (fill_value),
        .fill_done  (fill_done),
`endif
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_we     (mem_we),
        .mem_q      (mem_q)
    );

    // Sync-read single-port memory standing in for port A.
    logic [15:0] dmem [1024];
    always @(posedge clk) begin
        if (mem_we) dmem[mem_addr] <= mem_data;
        mem_q <= dmem[mem_addr];
    end

    // Transaction-level model: edge count, blocking window, pending response.
    int unsigned n = 0;
    int unsigned blocked_until = 0;
    int unsigned rsp_edge = 0;
    bit          pend = 0;
    logic [15:0] pend_data = '0;
    bit          m_we = 0, m_rsp = 0, m_done = 0;
    logic [9:0]  m_addr = '0;
    logic [15:0] m_data = '0, m_rdata = '0;
    logic [15:0] exp_mem [1024];
`ifdef MEM_CTRL_FILL_EN
    bit          f_act = 0;
    int unsigned f_i = 0, f_len = 0;
    logic [9:0]  f_base = '0;
    logic [15:0] f_val = '0;
`endif

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                blocked_until = n;
                pend = 0;
                m_we = 0; m_rsp = 0; m_done = 0;
                m_addr = '0; m_data = '0; m_rdata = '0;
`ifdef MEM_CTRL_FILL_EN
                f_act = 0;
`endif
            end else begin
                bit rdy;
                rdy = (n >= blocked_until);
                n = n + 1;
                m_we = 0; m_rsp = 0; m_done = 0;
                if (pend && n == rsp_edge) begin
                    m_rsp = 1; m_rdata = pend_data; pend = 0;
                end
`ifdef MEM_CTRL_FILL_EN
                if (f_act) begin
                    if (f_i < f_len) begin
                        m_we = 1;
                        m_addr = 10'((int'(f_base) + f_i) % 1024);
                        m_data = f_val;
                        exp_mem[m_addr] = f_val;
                        f_i++;
                    end else begin
                        m_done = 1; f_act = 0;
                    end
                end
                if (rdy && fill_start) begin
                    f_act = 1; f_i = 0; f_len = fill_len; f_base = fill_base; f_val = fill_value;
                    blocked_until = n + f_len + 1;
                end else
`endif
                if (rdy && req_valid) begin
                    m_addr = req_addr;
                    if (req_we) begin
                        m_we = 1; m_data = req_wdata;
                        exp_mem[req_addr] = req_wdata;
                    end else begin
                        pend = 1; rsp_edge = n + 2; pend_data = exp_mem[req_addr];
                        blocked_until = n + 2;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    logic [15:0] rsp_log [$];

    // Per-cycle compare against the model.
    initial begin
        forever begin
            bit exp_rdy;
            @(negedge clk);
            exp_rdy = !reset && (n >= blocked_until);
`ifdef MEM_CTRL_FILL_EN
            exp_rdy = exp_rdy && !fill_start;
            chk("fill_done", 32'(fill_done), 32'(m_done));
`endif
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("busy", 32'(busy), 32'(!reset && n < blocked_until));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp));
            chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
            chk("mem_we", 32'(mem_we), 32'(m_we));
            chk("mem_addr", 32'(mem_addr), 32'(m_addr));
            chk("mem_data", 32'(mem_data), 32'(m_data));
            if (rsp_valid) rsp_log.push_back(rsp_rdata);
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Present a request and hold it until accepted; returns the accept edge index.
    task automatic issue(input bit we, input logic [9:0] a, input logic [15:0] d,
                         output int unsigned acc);
        int k;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        chk("accept_in_time", 32'(k < 50), 32'd1);
        @(posedge clk);
        #1;
        acc = n;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int unsigned at, output logic [15:0] d);
        int k;
        for (k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        chk("rsp_in_time", 32'(k < 10), 32'd1);
        at = n;
        d = rsp_rdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned e1, e2, ra;
        logic [15:0] rd;
        int cnt;

        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(req_ready), 32'd1);
        sync();

        // Reset mid-load aborts the response.
        issue(1'b0, 10'd3, 16'h0, e1);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_mem_addr", 32'(mem_addr), 32'd0);
        chk("reset_ready", 32'(req_ready), 32'd0);
        sync();
        sync();
        reset = 1'b0;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rsp_valid) cnt++;
        end
        chk("no_rsp_after_abort", 32'(cnt), 32'd0);
        sync();

        // Store then load to the same address on consecutive accepts.
        issue(1'b1, 10'd1, 16'h0001, e1);
        issue(1'b0, 10'd1, 16'h0, e2);
        chk("store_load_consecutive", e2 - e1, 32'd1);
        wait_rsp(ra, rd);
        chk("load_latency", ra - e2, 32'd2);
        chk("load1_data", 32'(rd), 32'h0001);
        sync();

        // Back-to-back stores, then separate loads.
        issue(1'b1, 10'd4, 16'h0002, e1);
        issue(1'b1, 10'd5, 16'h00AA, e2);
        chk("store_b2b", e2 - e1, 32'd1);
        issue(1'b0, 10'd4, 16'h0, e1);
        wait_rsp(ra, rd);
        chk("load4_data", 32'(rd), 32'h0002);
        sync();
        issue(1'b0, 10'd5, 16'h0, e1);
        wait_rsp(ra, rd);
        chk("load5_data", 32'(rd), 32'h00AA);
        sync();

        // Second load held valid while the first is in flight.
        rsp_log.delete();
        issue(1'b0, 10'd5, 16'h0, e1);
        issue(1'b0, 10'd4, 16'h0, e2);
        chk("held_load_accept_gap", e2 - e1, 32'd3);
        wait_rsp(ra, rd);
        chk("held_rsp_count", 32'(rsp_log.size()), 32'd2);
        if (rsp_log.size() == 2) begin
            chk("held_rsp0", 32'(rsp_log[0]), 32'h00AA);
            chk("held_rsp1", 32'(rsp_log[1]), 32'h0002);
        end
        sync();

`ifdef MEM_CTRL_FILL_EN
        // Wrapping fill.
        fill_base = 10'd1022; fill_len = 11'd4; fill_value = 16'hBEEF; fill_start = 1'b1;
        sync();
        fill_start = 1'b0;
        e1 = n;
        cnt = 0; e2 = 0;
        begin
            int dn;
            dn = 0;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                if (mem_we) cnt++;
                if (fill_done) begin dn++; e2 = n; end
            end
            chk("fill_we_count", 32'(cnt), 32'd4);
            chk("fill_done_count", 32'(dn), 32'd1);
            chk("fill_done_edge", e2 - e1, 32'd5);
        end
        chk("fill_mem0", 32'(dmem[0]), 32'hBEEF);
        sync();
        issue(1'b0, 10'd1022, 16'h0, e1);
        wait_rsp(ra, rd);
        chk("fill_load1022", 32'(rd), 32'hBEEF);
        sync();
        issue(1'b0, 10'd1, 16'h0, e1);
        wait_rsp(ra, rd);
        chk("fill_load1", 32'(rd), 32'hBEEF);
        sync();

        // Zero-length fill.
        fill_len = 11'd0; fill_start = 1'b1;
        sync();
        fill_start = 1'b0;
        e1 = n;
        cnt = 0; e2 = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (mem_we) cnt++;
            if (fill_done) e2 = n;
        end
        chk("fill0_no_we", 32'(cnt), 32'd0);
        chk("fill0_done_edge", e2 - e1, 32'd1);
        sync();

        // Fill wins over a same-cycle load; the load then sees the filled data.
        fill_base = 10'd10; fill_len = 11'd2; fill_value = 16'h1234; fill_start = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 10'd10;
        sync();
        fill_start = 1'b0;
        e1 = n;
        issue(1'b0, 10'd10, 16'h0, e2);
        chk("fill_priority_gap", e2 - e1, 32'd4);
        wait_rsp(ra, rd);
        chk("fill_then_load", 32'(rd), 32'h1234);
        sync();

        // Fill request during a load is ignored.
        issue(1'b0, 10'd4, 16'h0, e1);
        fill_base = 10'd4; fill_len = 11'd4; fill_value = 16'h0000; fill_start = 1'b1;
        sync();
        fill_start = 1'b0;
        wait_rsp(ra, rd);
        chk("busy_fill_ignored_rsp", 32'(rd), 32'h0002);
        sync();
        issue(1'b0, 10'd4, 16'h0, e1);
        wait_rsp(ra, rd);
        chk("busy_fill_ignored_mem", 32'(rd), 32'h0002);
        sync();
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
